// File: rtl/cc_collision_scan_controller.sv
// Walks every row of the obstacle RAM on a game tick and checks each one against player 1's position.
// Reports whether any row collided, the lowest row that hit, and how many rows hit.
module cc_collision_scan_controller #(
  parameter int DATAWIDTH     = 8,
  parameter int NUMROWS       = 8,
  parameter int ROWADDR_WIDTH = 3
) (
  input  logic                     CC_COLLISION_SCAN_CLOCK_50,
  input  logic                     CC_COLLISION_SCAN_RESET_InHigh,
  input  logic                     CC_COLLISION_SCAN_start,
  input  logic [DATAWIDTH-1:0]     CC_COLLISION_SCAN_posjug1,
  output logic [ROWADDR_WIDTH-1:0] CC_COLLISION_SCAN_rowaddr,
  input  logic [DATAWIDTH-1:0]     CC_COLLISION_SCAN_rowdata,
  output logic                     CC_COLLISION_SCAN_busy,
  output logic                     CC_COLLISION_SCAN_done,
  output logic                     CC_COLLISION_SCAN_collision,
  output logic [ROWADDR_WIDTH-1:0] CC_COLLISION_SCAN_hitrow,
  output logic [ROWADDR_WIDTH:0]   CC_COLLISION_SCAN_hitcount
);

  typedef enum logic [1:0] {IDLE, FETCH, CMP, DONE} stateT;

  localparam logic [ROWADDR_WIDTH-1:0] LASTROW = ROWADDR_WIDTH'(NUMROWS - 1);
  localparam logic [ROWADDR_WIDTH-1:0] ADDRONE = ROWADDR_WIDTH'(1);
  localparam logic [ROWADDR_WIDTH:0]   CNTONE  = (ROWADDR_WIDTH + 1)'(1);

  stateT                state;
  logic [DATAWIDTH-1:0] posReg;
  logic                 hit;

  // Only meaningful in CMP, when the RAM output belongs to the current rowaddr.
  assign hit = |(CC_COLLISION_SCAN_rowdata & posReg);

  always_ff @(posedge CC_COLLISION_SCAN_CLOCK_50 or posedge CC_COLLISION_SCAN_RESET_InHigh) begin
    if (CC_COLLISION_SCAN_RESET_InHigh) begin
      state                       <= IDLE;
      posReg                      <= '0;
      CC_COLLISION_SCAN_rowaddr   <= '0;
      CC_COLLISION_SCAN_busy      <= 1'b0;
      CC_COLLISION_SCAN_done      <= 1'b0;
      CC_COLLISION_SCAN_collision <= 1'b0;
      CC_COLLISION_SCAN_hitrow    <= '0;
      CC_COLLISION_SCAN_hitcount  <= '0;
    end else begin
      CC_COLLISION_SCAN_done <= 1'b0;
      case (state)
        IDLE: begin
          if (CC_COLLISION_SCAN_start) begin
            posReg                      <= CC_COLLISION_SCAN_posjug1;
            CC_COLLISION_SCAN_collision <= 1'b0;
            CC_COLLISION_SCAN_hitrow    <= '0;
            CC_COLLISION_SCAN_hitcount  <= '0;
            CC_COLLISION_SCAN_rowaddr   <= '0;
            CC_COLLISION_SCAN_busy      <= 1'b1;
            state                       <= FETCH;
          end
        end
        FETCH: state <= CMP;
        CMP: begin
          if (hit) begin
            CC_COLLISION_SCAN_hitcount <= CC_COLLISION_SCAN_hitcount + CNTONE;
            if (!CC_COLLISION_SCAN_collision) begin
              CC_COLLISION_SCAN_collision <= 1'b1;
              CC_COLLISION_SCAN_hitrow    <= CC_COLLISION_SCAN_rowaddr;
            end
          end
          // done and busy change on the same edge as the last compare so results are final when done rises.
          if (CC_COLLISION_SCAN_rowaddr == LASTROW) begin
            CC_COLLISION_SCAN_rowaddr <= '0;
            CC_COLLISION_SCAN_busy    <= 1'b0;
            CC_COLLISION_SCAN_done    <= 1'b1;
            state                     <= DONE;
          end else begin
            CC_COLLISION_SCAN_rowaddr <= CC_COLLISION_SCAN_rowaddr + ADDRONE;
            state                     <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_collision_scan_controller.sv
// Directed bench for cc_collision_scan_controller: stimulus pushes expected results, a monitor checks each done pulse.
module tb_cc_collision_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] posjug1;
  logic [2:0] rowaddr;
  logic [7:0] rowdata = '0;
  logic       busy;
  logic       done;
  logic       collision;
  logic [2:0] hitrow;
  logic [3:0] hitcount;

  logic [7:0] mem [8];

  typedef struct {
    logic       coll;
    logic [2:0] row;
    logic [3:0] cnt;
    int         doneCyc;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  logic prevDone = 1'b0;

  cc_collision_scan_controller #(
    .DATAWIDTH(8), .NUMROWS(8), .ROWADDR_WIDTH(3)
  ) dut (
    .CC_COLLISION_SCAN_CLOCK_50    (clk),
    .CC_COLLISION_SCAN_RESET_InHigh(rst),
    .CC_COLLISION_SCAN_start       (start),
    .CC_COLLISION_SCAN_posjug1     (posjug1),
    .CC_COLLISION_SCAN_rowaddr     (rowaddr),
    .CC_COLLISION_SCAN_rowdata     (rowdata),
    .CC_COLLISION_SCAN_busy        (busy),
    .CC_COLLISION_SCAN_done        (done),
    .CC_COLLISION_SCAN_collision   (collision),
    .CC_COLLISION_SCAN_hitrow      (hitrow),
    .CC_COLLISION_SCAN_hitcount    (hitcount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rowdata <= mem[rowaddr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_width", prevDone, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        expT e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.doneCyc);
        chk("collision", collision, e.coll);
        chk("hitrow", hitrow, e.row);
        chk("hitcount", hitcount, e.cnt);
      end
    end
    prevDone <= done;
  end

  task automatic checkAllZero(input string tag);
    chk({tag, "_rowaddr"}, rowaddr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_collision"}, collision, 0);
    chk({tag, "_hitrow"}, hitrow, 0);
    chk({tag, "_hitcount"}, hitcount, 0);
  endtask

  task automatic setMap(input logic [7:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v;
  endtask

  // Returns just after the edge E0 that samples start.
  task automatic issue(input logic [7:0] p, input logic c, input logic [2:0] r, input logic [3:0] n);
    expT e;
    @(posedge clk); #1;
    posjug1 = p;
    start   = 1'b1;
    e.coll = c; e.row = r; e.cnt = n; e.doneCyc = cyc + 1 + 16;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    chk("scan_completes", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int  busyCnt;
    bit  found;
    expT e;
    rst = 1'b0; start = 1'b0; posjug1 = '0;
    setMap(8'h00);

    // Reset raised mid-clock with start held high.
    #2 rst = 1'b1; start = 1'b1; posjug1 = 8'hAA;
    #1 checkAllZero("reset_async");
    repeat (3) @(posedge clk);
    #1 chk("busy_in_reset", busy, 0);
    @(negedge clk) start = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_after_reset", busy, 0);

    // Empty map.
    setMap(8'h00);
    issue(8'h10, 1'b0, 3'd0, 4'd0);
    busyCnt = 0;
    repeat (20) @(negedge clk) if (busy) busyCnt++;
    chk("busy_cycles", busyCnt, 16);
    waitDrain();

    // Single hit on row 5, plus the rowaddr sequence.
    mem[5] = 8'h18;
    issue(8'h08, 1'b1, 3'd5, 4'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rowaddr_seq", rowaddr, i / 2);
    end
    waitDrain();
    repeat (5) @(posedge clk);
    #1 chk("hold_collision", collision, 1);
    chk("hold_hitrow", hitrow, 5);

    // Two hits; position change and a stray start mid-scan are ignored.
    setMap(8'h00);
    mem[2] = 8'hFF; mem[6] = 8'hFF;
    issue(8'h01, 1'b1, 3'd2, 4'd2);
    repeat (3) @(posedge clk);
    #1 posjug1 = 8'h80; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waitDrain();
    repeat (20) @(posedge clk);

    // Reset while rowaddr=3 aborts the scan without a done pulse.
    setMap(8'h00);
    mem[0] = 8'h01;
    issue(8'h01, 1'b1, 3'd0, 4'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (rowaddr == 3'd3) found = 1'b1;
    end
    chk("reach_row3", found, 1);
    #2 rst = 1'b1;
    #1 checkAllZero("reset_midscan");
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (25) @(posedge clk);
    issue(8'h01, 1'b1, 3'd0, 4'd1);
    waitDrain();

    // Zero position on a full map, then start in DONE (ignored) held into IDLE (accepted).
    setMap(8'hFF);
    issue(8'h00, 1'b0, 3'd0, 4'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    chk("zero_pos_done_seen", found, 1);
    start = 1'b1; posjug1 = 8'h01;
    e.coll = 1'b1; e.row = 3'd0; e.cnt = 4'd8; e.doneCyc = cyc + 18;
    sb.push_back(e);
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    waitDrain();

    repeat (10) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_collision_scan_controller.md
Name: cc_collision_scan_controller

Overview:
- Sequences the player-1 position check over the whole game matrix instead of a single hard-wired row.
- On each game tick it walks every row of the obstacle RAM and compares the row contents against player 1's one-hot position.
- It reports whether a collision occurred, the first row that hit, and the total hit count.
- It sits between the game-tick generator, the obstacle matrix RAM (synchronous read) and the game-over/score logic.

Parameters:
- DATAWIDTH, 8, width of one matrix row and of the player position bus (one bit per column).
- NUMROWS, 8, number of rows scanned (rows 0..NUMROWS-1); must be ≥1 and ≤2^ROWADDR_WIDTH.
- ROWADDR_WIDTH, 3, width of the row address bus.

Ports:
- CC_COLLISION_SCAN_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- CC_COLLISION_SCAN_RESET_InHigh  in  1  asynchronous, active-high reset.
- CC_COLLISION_SCAN_start  in  1  single-cycle scan request from the game-tick generator.
- CC_COLLISION_SCAN_posjug1  in  DATAWIDTH  player-1 position, one-hot column.
- CC_COLLISION_SCAN_rowaddr  out  ROWADDR_WIDTH  row address to the matrix RAM.
- CC_COLLISION_SCAN_rowdata  in  DATAWIDTH  RAM read data, valid one clock after rowaddr.
- CC_COLLISION_SCAN_busy  out  1  high while a scan is in progress.
- CC_COLLISION_SCAN_done  out  1  one-cycle pulse when results are final.
- CC_COLLISION_SCAN_collision  out  1  at least one row overlapped the player position.
- CC_COLLISION_SCAN_hitrow  out  ROWADDR_WIDTH  lowest row index that hit.
- CC_COLLISION_SCAN_hitcount  out  ROWADDR_WIDTH+1  number of rows that hit.

Behaviour:
- Asynchronous reset (any time, including mid-scan):
  - state=IDLE.
  - rowaddr, busy, done, collision, hitrow and hitcount all =0.
  - Internal position register =0.
  - No done pulse is produced for the aborted scan.
- All outputs are registered or decoded from state (Moore); none are combinational from inputs.
- FSM states and transitions:
  - IDLE: start=1 → capture posjug1 into the position register, clear collision/hitrow/hitcount, set rowaddr=0, go to FETCH. start=0 → stay in IDLE. Previous results hold in IDLE.
  - FETCH: rowaddr is stable; the RAM registers data. Always go to CMP.
  - CMP: rowdata is valid. hit = OR-reduction of (rowdata AND position register).
    - On hit: hitcount+1; if collision was 0, set collision=1 and hitrow=rowaddr.
    - If rowaddr==NUMROWS-1 → go to DONE. Otherwise rowaddr+1 → go to FETCH.
  - DONE: done=1 for exactly this cycle; rowaddr returns to 0; always go to IDLE.
- busy=1 in FETCH and CMP only.
- Latency:
  - Define edge E0 as the clock edge that samples start.
  - done is visible after edge E0+2·NUMROWS (16 edges at defaults) and lasts one cycle.
  - Results are final when done rises and hold until the next accepted start.
- start is accepted only in IDLE. start in FETCH, CMP or DONE is ignored and not queued.
- posjug1 changes after E0 do not affect the running scan.
- A position register of 0x00 never produces a hit. Multi-bit position values are ANDed as given; no one-hot check.
- hitcount saturates naturally: at most NUMROWS, which fits in ROWADDR_WIDTH+1 bits.
- rowaddr never exceeds NUMROWS-1, including when NUMROWS < 2^ROWADDR_WIDTH.

Test Plan:
- Reset check: assert reset mid-clock → all outputs 0 and rowaddr=0 immediately, without waiting for a clock edge. Hold start=1 during reset → no scan starts.
- Empty map: all rows 0x00, posjug1=0x10, one start pulse → busy high for 16 cycles, then done pulse 16 edges after E0; collision=0, hitcount=0, hitrow=0.
- Single hit: row5=0x18, other rows 0x00, posjug1=0x08 → collision=1, hitrow=5, hitcount=1. Also check rowaddr sequence 0,0,1,1,…,7,7.
- Multi-hit and input stability:
  - Setup: rows 2 and 6 =0xFF, posjug1=0x01 at start.
  - Stimulus: change posjug1 to 0x80 and pulse start at E0+4.
  - Required: hitrow=2, hitcount=2, only one done pulse at E0+16.
- Reset mid-scan: reset asserted while rowaddr=3 → no done pulse. A new start afterwards, on a map with row0=0x01 and posjug1=0x01, completes normally with collision=1, hitrow=0, hitcount=1.
- Back-to-back and zero position:
  - start asserted in the DONE cycle → ignored. start one cycle later → accepted.
  - All rows 0xFF with posjug1=0x00 → collision=0, hitcount=0.
